// File: rtl/arm_lsu.sv
// arm_lsu: load/store unit between the core memory stage and a valid/ready data bus.
// The core holds req until done; the unit latches the request, runs one bus transfer
// (or faults straight away), then pulses done for a single cycle.
//
// Optional feature macro: ARM_LSU_HALFWORD_EN. When defined, size 01 is a legal halfword
// access. When undefined, size 01 faults with code 11 and no halfword datapath is built.
//
// Ports:
//   clk, reset             clock, asynchronous active-low reset
//   req, we, size          core request, store select, access size (00 B, 01 H, 10 W)
//   signed_ld, addr, wdata sign-extend loads, byte address, right-aligned store data
//   stall, done            req & ~done; one-cycle completion pulse
//   rdata, fault           extended load data and fault flag, both valid with done
//   fault_code             01 misaligned, 10 timeout, 11 unsupported size
//   mem_*                  registered bus request; mem_rdata sampled on mem_valid & mem_ready
module arm_lsu #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned TIMEOUT    = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req,
  input  logic                  we,
  input  logic [1:0]            size,
  input  logic                  signed_ld,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [31:0]           wdata,
  output logic                  stall,
  output logic                  done,
  output logic [31:0]           rdata,
  output logic                  fault,
  output logic [1:0]            fault_code,
  output logic                  mem_valid,
  input  logic                  mem_ready,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [3:0]            mem_be,
  output logic [31:0]           mem_wdata,
  input  logic [31:0]           mem_rdata
);

  // A zero TIMEOUT still needs a one-bit counter so the declarations stay legal.
  localparam int unsigned CntW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CntW-1:0] CntLast = (TIMEOUT > 0) ? CntW'(TIMEOUT - 1) : '0;

  typedef enum logic [1:0] {StIdle, StBus, StDone} state_e;

  state_e                state_q, state_d;
  logic                  we_q, we_d;
  logic [1:0]            size_q, size_d;
  logic                  signed_q, signed_d;
  logic [1:0]            addr_lo_q, addr_lo_d;
  logic [CntW-1:0]       cnt_q, cnt_d;
  logic                  mem_valid_q, mem_valid_d;
  logic                  mem_we_q, mem_we_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [3:0]            mem_be_q, mem_be_d;
  logic [31:0]           mem_wdata_q, mem_wdata_d;
  logic                  fault_q, fault_d;
  logic [1:0]            fault_code_q, fault_code_d;
  logic [31:0]           rdata_q, rdata_d;

  logic [7:0]            ld_byte;
  logic [31:0]           ld_data;
  logic [3:0]            req_be;
  logic [31:0]           req_wdata;
  logic                  req_illegal;
  logic                  req_misaligned;
`ifdef ARM_LSU_HALFWORD_EN
  logic [15:0]           ld_half;
`endif

  // Decode the incoming request: lane enables, replicated store data, fault causes.
  always_comb begin
    req_be         = 4'b0000;
    req_wdata      = wdata;
    req_illegal    = 1'b0;
    req_misaligned = 1'b0;
    case (size)
      2'b00: begin
        req_be    = 4'b0001 << addr[1:0];
        req_wdata = {4{wdata[7:0]}};
      end
      2'b01: begin
`ifdef ARM_LSU_HALFWORD_EN
        req_misaligned = addr[0];
        req_be         = addr[1] ? 4'b1100 : 4'b0011;
        req_wdata      = {2{wdata[15:0]}};
`else
        req_illegal    = 1'b1;
`endif
      end
      2'b10: begin
        req_misaligned = (addr[1:0] != 2'b00);
        req_be         = 4'b1111;
      end
      default: req_illegal = 1'b1;
    endcase
  end

  // Pick the addressed lane out of the bus word and extend it.
  always_comb begin
    ld_byte = 8'h00;
    ld_data = mem_rdata;
    case (addr_lo_q)
      2'b00:   ld_byte = mem_rdata[7:0];
      2'b01:   ld_byte = mem_rdata[15:8];
      2'b10:   ld_byte = mem_rdata[23:16];
      default: ld_byte = mem_rdata[31:24];
    endcase
`ifdef ARM_LSU_HALFWORD_EN
    ld_half = addr_lo_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
`endif
    case (size_q)
      2'b00:   ld_data = {{24{signed_q & ld_byte[7]}}, ld_byte};
`ifdef ARM_LSU_HALFWORD_EN
      2'b01:   ld_data = {{16{signed_q & ld_half[15]}}, ld_half};
`endif
      default: ld_data = mem_rdata;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    we_d         = we_q;
    size_d       = size_q;
    signed_d     = signed_q;
    addr_lo_d    = addr_lo_q;
    cnt_d        = cnt_q;
    mem_valid_d  = mem_valid_q;
    mem_we_d     = mem_we_q;
    mem_addr_d   = mem_addr_q;
    mem_be_d     = mem_be_q;
    mem_wdata_d  = mem_wdata_q;
    fault_d      = fault_q;
    fault_code_d = fault_code_q;
    rdata_d      = rdata_q;
    case (state_q)
      StIdle: begin
        if (req) begin
          we_d      = we;
          size_d    = size;
          signed_d  = signed_ld;
          addr_lo_d = addr[1:0];
          rdata_d   = 32'h0;
          cnt_d     = '0;
          if (req_illegal) begin
            state_d      = StDone;
            fault_d      = 1'b1;
            fault_code_d = 2'b11;
          end else if (req_misaligned) begin
            state_d      = StDone;
            fault_d      = 1'b1;
            fault_code_d = 2'b01;
          end else begin
            state_d     = StBus;
            mem_valid_d = 1'b1;
            mem_we_d    = we;
            mem_addr_d  = {addr[ADDR_WIDTH-1:2], 2'b00};
            mem_be_d    = req_be;
            mem_wdata_d = req_wdata;
          end
        end
      end
      StBus: begin
        // A response in the last watchdog cycle still completes normally.
        if (mem_ready) begin
          state_d      = StDone;
          mem_valid_d  = 1'b0;
          cnt_d        = '0;
          fault_d      = 1'b0;
          fault_code_d = 2'b00;
          rdata_d      = we_q ? 32'h0 : ld_data;
        end else if (TIMEOUT != 0 && cnt_q == CntLast) begin
          state_d      = StDone;
          mem_valid_d  = 1'b0;
          cnt_d        = '0;
          fault_d      = 1'b1;
          fault_code_d = 2'b10;
          rdata_d      = 32'h0;
        end else if (TIMEOUT != 0) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StDone: begin
        // The req still high here belongs to the access that is finishing.
        state_d      = StIdle;
        fault_d      = 1'b0;
        fault_code_d = 2'b00;
        rdata_d      = 32'h0;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= StIdle;
      we_q         <= 1'b0;
      size_q       <= 2'b00;
      signed_q     <= 1'b0;
      addr_lo_q    <= 2'b00;
      cnt_q        <= '0;
      mem_valid_q  <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_be_q     <= 4'b0000;
      mem_wdata_q  <= 32'h0;
      fault_q      <= 1'b0;
      fault_code_q <= 2'b00;
      rdata_q      <= 32'h0;
    end else begin
      state_q      <= state_d;
      we_q         <= we_d;
      size_q       <= size_d;
      signed_q     <= signed_d;
      addr_lo_q    <= addr_lo_d;
      cnt_q        <= cnt_d;
      mem_valid_q  <= mem_valid_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_be_q     <= mem_be_d;
      mem_wdata_q  <= mem_wdata_d;
      fault_q      <= fault_d;
      fault_code_q <= fault_code_d;
      rdata_q      <= rdata_d;
    end
  end

  assign done       = (state_q == StDone);
  assign stall      = req & ~done;
  assign rdata      = rdata_q;
  assign fault      = fault_q;
  assign fault_code = fault_code_q;
  assign mem_valid  = mem_valid_q;
  assign mem_we     = mem_we_q;
  assign mem_addr   = mem_addr_q;
  assign mem_be     = mem_be_q;
  assign mem_wdata  = mem_wdata_q;

endmodule

// File: tb/tb_arm_lsu.sv
// Directed bench for arm_lsu with TIMEOUT = 4. Expected values are hand-computed.
module tb_arm_lsu;

  logic        clk = 1'b0;
  logic        reset;
  logic        req;
  logic        we;
  logic [1:0]  size;
  logic        signed_ld;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        stall;
  logic        done;
  logic [31:0] rdata;
  logic        fault;
  logic [1:0]  fault_code;
  logic        mem_valid;
  logic        mem_ready;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  arm_lsu #(
    .ADDR_WIDTH(32),
    .TIMEOUT   (4)
  ) u_dut (
    .clk       (clk),
    .reset     (reset),
    .req       (req),
    .we        (we),
    .size      (size),
    .signed_ld (signed_ld),
    .addr      (addr),
    .wdata     (wdata),
    .stall     (stall),
    .done      (done),
    .rdata     (rdata),
    .fault     (fault),
    .fault_code(fault_code),
    .mem_valid (mem_valid),
    .mem_ready (mem_ready),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_be    (mem_be),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Results of the most recent access.
  int          valid_cnt;
  int          done_cyc;
  int          unstable;
  logic        stall_at_done;
  logic [31:0] rdata_at_done;
  logic        fault_at_done;
  logic [1:0]  code_at_done;
  logic [3:0]  cap_be;
  logic [31:0] cap_addr;
  logic [31:0] cap_wdata;
  logic        cap_we;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Runs one access starting in an IDLE cycle. mem_ready is raised in the (waits+1)-th
  // cycle of mem_valid. Request inputs are scrambled after cycle 0 to prove latching.
  task automatic run_access(input logic w, input logic [1:0] sz, input logic sg,
                            input logic [31:0] a, input logic [31:0] wd,
                            input logic [31:0] bus_rd, input int waits);
    req = 1'b1; we = w; size = sz; signed_ld = sg; addr = a; wdata = wd;
    mem_rdata = bus_rd; mem_ready = 1'b0;
    valid_cnt = 0; done_cyc = -1; unstable = 0;
    stall_at_done = 1'bx; rdata_at_done = 'x; fault_at_done = 1'bx; code_at_done = 'x;
    cap_be = 'x; cap_addr = 'x; cap_wdata = 'x; cap_we = 1'bx;
    for (int c = 0; c < 40; c++) begin
      if (c == 1) begin
        we = ~w; size = ~sz; signed_ld = ~sg; addr = ~a; wdata = ~wd;
      end
      if (done) begin
        done_cyc      = c;
        stall_at_done = stall;
        rdata_at_done = rdata;
        fault_at_done = fault;
        code_at_done  = fault_code;
        req           = 1'b0;
        mem_ready     = 1'b0;
        break;
      end
      if (mem_valid) begin
        valid_cnt++;
        if (valid_cnt == 1) begin
          cap_be = mem_be; cap_addr = mem_addr; cap_wdata = mem_wdata; cap_we = mem_we;
        end else if (mem_be !== cap_be || mem_addr !== cap_addr || mem_wdata !== cap_wdata) begin
          unstable++;
        end
      end
      mem_ready = mem_valid && (valid_cnt == waits + 1);
      step();
    end
    req = 1'b0;
    mem_ready = 1'b0;
    // Leave DONE so the next access starts from IDLE.
    step();
  endtask

  initial begin
    int done_seen;
    reset = 1'b0; req = 1'b0; we = 1'b0; size = 2'b00; signed_ld = 1'b0;
    addr = 32'h0; wdata = 32'h0; mem_ready = 1'b0; mem_rdata = 32'h0;
    step();
    req = 1'b1;
    #1;
    check_eq("rst_mem_valid", {31'h0, mem_valid}, 32'h0);
    check_eq("rst_done", {31'h0, done}, 32'h0);
    check_eq("rst_rdata", rdata, 32'h0);
    check_eq("rst_fault", {29'h0, fault, fault_code}, 32'h0);
    check_eq("rst_bus", {mem_be, 3'h0, mem_we} ^ mem_addr ^ mem_wdata, 32'h0);
    check_eq("rst_stall_follows_req", {31'h0, stall}, 32'h1);
    req = 1'b0;
    step();
    reset = 1'b1;
    step();

    // Word store, two wait cycles.
    run_access(1'b1, 2'b10, 1'b0, 32'h100, 32'hDEADBEEF, 32'h0, 2);
    check_eq("ws_valid_cycles", valid_cnt, 3);
    check_eq("ws_be", {28'h0, cap_be}, 32'hF);
    check_eq("ws_addr", cap_addr, 32'h100);
    check_eq("ws_wdata", cap_wdata, 32'hDEADBEEF);
    check_eq("ws_we", {31'h0, cap_we}, 32'h1);
    check_eq("ws_stable", unstable, 0);
    check_eq("ws_done_cycle", done_cyc, 4);
    check_eq("ws_stall_at_done", {31'h0, stall_at_done}, 32'h0);
    check_eq("ws_fault", {31'h0, fault_at_done}, 32'h0);
    check_eq("ws_rdata", rdata_at_done, 32'h0);

    // Byte loads from lane 3.
    run_access(1'b0, 2'b00, 1'b1, 32'h103, 32'h0, 32'h80FF1234, 0);
    check_eq("lbs_rdata", rdata_at_done, 32'hFFFFFF80);
    check_eq("lbs_done_cycle", done_cyc, 2);
    check_eq("lbs_be", {28'h0, cap_be}, 32'h8);
    check_eq("lbs_we", {31'h0, cap_we}, 32'h0);
    run_access(1'b0, 2'b00, 1'b0, 32'h103, 32'h0, 32'h80FF1234, 1);
    check_eq("lbu_rdata", rdata_at_done, 32'h00000080);
    check_eq("lbu_done_cycle", done_cyc, 3);
    run_access(1'b0, 2'b00, 1'b1, 32'h101, 32'h0, 32'h80FF1234, 0);
    check_eq("lbs_lane1_rdata", rdata_at_done, 32'h00000012);

    // Byte store to lane 2.
    run_access(1'b1, 2'b00, 1'b0, 32'h102, 32'h000000AB, 32'h0, 0);
    check_eq("sb_be", {28'h0, cap_be}, 32'h4);
    check_eq("sb_wdata", cap_wdata, 32'hABABABAB);
    check_eq("sb_addr", cap_addr, 32'h100);

    // Misaligned word load: no bus cycle.
    run_access(1'b0, 2'b10, 1'b0, 32'h101, 32'h0, 32'h0, 0);
    check_eq("mis_valid_cycles", valid_cnt, 0);
    check_eq("mis_done_cycle", done_cyc, 1);
    check_eq("mis_fault", {29'h0, fault_at_done, code_at_done}, 32'h5);

    // Illegal size.
    run_access(1'b0, 2'b11, 1'b0, 32'h100, 32'h0, 32'h0, 0);
    check_eq("ill_valid_cycles", valid_cnt, 0);
    check_eq("ill_fault", {29'h0, fault_at_done, code_at_done}, 32'h7);

    // Watchdog expiry with mem_ready never asserted.
    run_access(1'b0, 2'b10, 1'b0, 32'h200, 32'h0, 32'h12345678, 99);
    check_eq("to_valid_cycles", valid_cnt, 4);
    check_eq("to_done_cycle", done_cyc, 5);
    check_eq("to_fault", {29'h0, fault_at_done, code_at_done}, 32'h6);
    check_eq("to_rdata", rdata_at_done, 32'h0);

    // mem_ready in the timeout cycle wins.
    run_access(1'b0, 2'b10, 1'b0, 32'h200, 32'h0, 32'h12345678, 3);
    check_eq("tow_valid_cycles", valid_cnt, 4);
    check_eq("tow_fault", {31'h0, fault_at_done}, 32'h0);
    check_eq("tow_rdata", rdata_at_done, 32'h12345678);

    // Halfword accesses.
    run_access(1'b0, 2'b01, 1'b1, 32'h202, 32'h0, 32'h80010000, 0);
`ifdef ARM_LSU_HALFWORD_EN
    check_eq("lhs_rdata", rdata_at_done, 32'hFFFF8001);
    check_eq("lhs_be", {28'h0, cap_be}, 32'hC);
    check_eq("lhs_fault", {31'h0, fault_at_done}, 32'h0);
    run_access(1'b1, 2'b01, 1'b0, 32'h200, 32'h00001234, 32'h0, 0);
    check_eq("sh_be", {28'h0, cap_be}, 32'h3);
    check_eq("sh_wdata", cap_wdata, 32'h12341234);
    run_access(1'b0, 2'b01, 1'b0, 32'h201, 32'h0, 32'h0, 0);
    check_eq("hmis_fault", {29'h0, fault_at_done, code_at_done}, 32'h5);
    check_eq("hmis_valid_cycles", valid_cnt, 0);
`else
    check_eq("lh_off_fault", {29'h0, fault_at_done, code_at_done}, 32'h7);
    check_eq("lh_off_valid_cycles", valid_cnt, 0);
    check_eq("lh_off_done_cycle", done_cyc, 1);
`endif

    // Reset in the middle of a bus cycle.
    req = 1'b1; we = 1'b1; size = 2'b10; signed_ld = 1'b0; addr = 32'h300;
    wdata = 32'hCAFEF00D; mem_ready = 1'b0;
    step();
    step();
    check_eq("mid_valid_before", {31'h0, mem_valid}, 32'h1);
    reset = 1'b0;
    #1;
    check_eq("mid_valid_dropped", {31'h0, mem_valid}, 32'h0);
    check_eq("mid_bus_cleared", {mem_be, 3'h0, mem_we} ^ mem_addr ^ mem_wdata, 32'h0);
    check_eq("mid_outputs", {rdata[30:0], done} | {29'h0, fault, fault_code}, 32'h0);
    req = 1'b0;
    step();
    reset = 1'b1;
    done_seen = 0;
    for (int i = 0; i < 6; i++) begin
      step();
      if (done || mem_valid) done_seen++;
    end
    check_eq("mid_no_done", done_seen, 0);

    // Normal operation resumes after reset.
    run_access(1'b0, 2'b10, 1'b0, 32'h104, 32'h0, 32'h0BADF00D, 0);
    check_eq("post_rst_rdata", rdata_at_done, 32'h0BADF00D);
    check_eq("post_rst_addr", cap_addr, 32'h104);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
